// File: rtl/conv_addr_gen.sv
// conv_addr_gen: address generator for a direct 2-D convolution sweep.
// Walks filter / output row / output column / kernel row / kernel column /
// channel, and emits one registered (source, weight, output) address tuple
// per accepted valid/ready handshake.
`timescale 1ns/1ps

module conv_addr_gen #(
    parameter int CONV_DIM_IMG    = 32,
    parameter int CONV_DIM_OUT    = 32,
    parameter int CONV_DIM_KERNEL = 5,
    parameter int CONV_DIM_CH     = 3,
    parameter int NUM_FILTERS     = 8,
    parameter int STRIDE          = 1,
    parameter int PADDING         = 2,
    parameter int ADDR_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ready,
    output logic              valid,
    output logic [ADDR_W-1:0] s_addr,
    output logic [ADDR_W-1:0] w_addr,
    output logic [ADDR_W-1:0] o_addr,
    output logic              pad,
    output logic              first,
    output logic              last,
    output logic              busy,
    output logic              done
);

    // Source coordinates can go negative by up to PADDING, so they are
    // evaluated two bits wider than the address width and signed.
    localparam int SW = ADDR_W + 2;

    typedef logic [ADDR_W-1:0] cnt_t;
    typedef logic signed [SW-1:0] coord_t;

    localparam cnt_t ONE     = cnt_t'(1);
    localparam cnt_t NF_MAX  = cnt_t'(NUM_FILTERS - 1);
    localparam cnt_t OUT_MAX = cnt_t'(CONV_DIM_OUT - 1);
    localparam cnt_t K_MAX   = cnt_t'(CONV_DIM_KERNEL - 1);
    localparam cnt_t CH_MAX  = cnt_t'(CONV_DIM_CH - 1);
    localparam cnt_t K_U     = cnt_t'(CONV_DIM_KERNEL);
    localparam cnt_t CH_U    = cnt_t'(CONV_DIM_CH);
    localparam cnt_t OUT_U   = cnt_t'(CONV_DIM_OUT);
    localparam cnt_t NF_U    = cnt_t'(NUM_FILTERS);
    localparam cnt_t W_FILT  = cnt_t'(CONV_DIM_CH * CONV_DIM_KERNEL * CONV_DIM_KERNEL);

    localparam coord_t STRIDE_S = coord_t'(STRIDE);
    localparam coord_t PAD_S    = coord_t'(PADDING);
    localparam coord_t IMG_S    = coord_t'(CONV_DIM_IMG);
    localparam coord_t CH_S     = coord_t'(CONV_DIM_CH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state;
    cnt_t   i, j, k, m, n, l;

    cnt_t   nxt_i, nxt_j, nxt_k, nxt_m, nxt_n, nxt_l;
    logic   l_wrap, n_wrap, m_wrap, k_wrap, j_wrap, sweep_end;
    coord_t row_s, col_s;
    logic   nxt_pad, nxt_first, nxt_last;
    cnt_t   nxt_s_addr, nxt_w_addr, nxt_o_addr;

    // Next counter values (odometer carry from l up to i) and the address
    // tuple they produce, so the outputs can be registered in step with them.
    always_comb begin
        // NOTE: every always_comb output is given a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        nxt_i = i;
        nxt_j = j;
        nxt_k = k;
        nxt_m = m;
        nxt_n = n;
        nxt_l = l;

        l_wrap    = (l == CH_MAX);
        n_wrap    = l_wrap && (n == K_MAX);
        m_wrap    = n_wrap && (m == K_MAX);
        k_wrap    = m_wrap && (k == OUT_MAX);
        j_wrap    = k_wrap && (j == OUT_MAX);
        sweep_end = j_wrap && (i == NF_MAX);

        if (state == IDLE) begin
            nxt_i = '0;
            nxt_j = '0;
            nxt_k = '0;
            nxt_m = '0;
            nxt_n = '0;
            nxt_l = '0;
        end else if (state == RUN && ready) begin
            nxt_l = l_wrap ? '0 : l + ONE;
            if (l_wrap) nxt_n = n_wrap ? '0 : n + ONE;
            if (n_wrap) nxt_m = m_wrap ? '0 : m + ONE;
            if (m_wrap) nxt_k = k_wrap ? '0 : k + ONE;
            if (k_wrap) nxt_j = j_wrap ? '0 : j + ONE;
            if (j_wrap) nxt_i = sweep_end ? '0 : i + ONE;
        end

        row_s = STRIDE_S * $signed({2'b00, nxt_j}) + $signed({2'b00, nxt_m}) - PAD_S;
        col_s = STRIDE_S * $signed({2'b00, nxt_k}) + $signed({2'b00, nxt_n}) - PAD_S;

        nxt_pad = row_s[SW-1] || (row_s >= IMG_S) || col_s[SW-1] || (col_s >= IMG_S);

        nxt_s_addr = nxt_pad ? '0
                   : cnt_t'((row_s * IMG_S + col_s) * CH_S + $signed({2'b00, nxt_l}));
        nxt_w_addr = nxt_i * W_FILT + (nxt_m * K_U + nxt_n) * CH_U + nxt_l;
        nxt_o_addr = (nxt_j * OUT_U + nxt_k) * NF_U + nxt_i;

        nxt_first = (nxt_m == '0) && (nxt_n == '0) && (nxt_l == '0);
        nxt_last  = (nxt_m == K_MAX) && (nxt_n == K_MAX) && (nxt_l == CH_MAX);
    end

    // Sweep FSM: owns the counters and every registered output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            i      <= '0;
            j      <= '0;
            k      <= '0;
            m      <= '0;
            n      <= '0;
            l      <= '0;
            valid  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            pad    <= 1'b0;
            first  <= 1'b0;
            last   <= 1'b0;
            s_addr <= '0;
            w_addr <= '0;
            o_addr <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= RUN;
                        valid  <= 1'b1;
                        busy   <= 1'b1;
                        i      <= nxt_i;
                        j      <= nxt_j;
                        k      <= nxt_k;
                        m      <= nxt_m;
                        n      <= nxt_n;
                        l      <= nxt_l;
                        pad    <= nxt_pad;
                        first  <= nxt_first;
                        last   <= nxt_last;
                        s_addr <= nxt_s_addr;
                        w_addr <= nxt_w_addr;
                        o_addr <= nxt_o_addr;
                    end
                end
                RUN: begin
                    if (ready) begin
                        i <= nxt_i;
                        j <= nxt_j;
                        k <= nxt_k;
                        m <= nxt_m;
                        n <= nxt_n;
                        l <= nxt_l;
                        if (sweep_end) begin
                            state <= DONE;
                            valid <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            pad    <= nxt_pad;
                            first  <= nxt_first;
                            last   <= nxt_last;
                            s_addr <= nxt_s_addr;
                            w_addr <= nxt_w_addr;
                            o_addr <= nxt_o_addr;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_addr_gen.sv
// tb_conv_addr_gen: self-checking bench for conv_addr_gen using a small
// geometry; expected tuples come from a nested-loop model of the sweep.
`timescale 1ns/1ps

module tb_conv_addr_gen;

    localparam int IMG = 4;
    localparam int OUT = 4;
    localparam int K   = 3;
    localparam int CH  = 2;
    localparam int NF  = 2;
    localparam int STR = 1;
    localparam int PD  = 1;
    localparam int AW  = 16;
    localparam int TOTAL = NF * OUT * OUT * K * K * CH;

    logic          clk = 1'b0;
    logic          rst, start, ready;
    logic          valid, pad, first, last, busy, done;
    logic [AW-1:0] s_addr, w_addr, o_addr;

    always #5 clk = ~clk;

    conv_addr_gen #(
        .CONV_DIM_IMG(IMG), .CONV_DIM_OUT(OUT), .CONV_DIM_KERNEL(K),
        .CONV_DIM_CH(CH), .NUM_FILTERS(NF), .STRIDE(STR), .PADDING(PD), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready), .valid(valid),
        .s_addr(s_addr), .w_addr(w_addr), .o_addr(o_addr), .pad(pad),
        .first(first), .last(last), .busy(busy), .done(done)
    );

    typedef struct packed {
        logic          valid, busy, done, pad, first, last;
        logic [AW-1:0] s, w, o;
    } tuple_t;

    typedef struct {
        int            idx;
        logic          pad, first, last;
        logic [AW-1:0] s, w, o;
    } vec_t;

    tuple_t cap[$];
    tuple_t model[$];
    vec_t   vecs[7];
    int     n_cmp  = 0;
    int     n_fail = 0;
    bit     got_done;

    function automatic tuple_t sample();
        return '{valid, busy, done, pad, first, last, s_addr, w_addr, o_addr};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the sweep written as plain nested loops over the spec formulas.
    task automatic build_model();
        int row, col, s, w, o;
        bit p;
        model.delete();
        for (int fi = 0; fi < NF; fi++)
            for (int oj = 0; oj < OUT; oj++)
                for (int ok = 0; ok < OUT; ok++)
                    for (int km = 0; km < K; km++)
                        for (int kn = 0; kn < K; kn++)
                            for (int cl = 0; cl < CH; cl++) begin
                                row = STR * oj + km - PD;
                                col = STR * ok + kn - PD;
                                p = (row < 0) || (row >= IMG) || (col < 0) || (col >= IMG);
                                s = p ? 0 : (row * IMG + col) * CH + cl;
                                w = fi * CH * K * K + (km * K + kn) * CH + cl;
                                o = (oj * OUT + ok) * NF + fi;
                                model.push_back('{1'b1, 1'b1, 1'b0, p,
                                                  (km == 0 && kn == 0 && cl == 0),
                                                  (km == K-1 && kn == K-1 && cl == CH-1),
                                                  AW'(s), AW'(w), AW'(o)});
                            end
    endtask

    // One sweep: pulse (or hold) start, drive ready, record accepted tuples,
    // and check outputs stay put across every stalled cycle.
    task automatic sweep(input bit rand_ready, input bit poke, input bit hold,
                         input int stop_at, output bit seen_done);
        tuple_t cur, held;
        bit     hold_chk = 1'b0;
        cap.delete();
        seen_done = 1'b0;
        @(negedge clk);
        start = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        start = hold;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            cur = sample();
            if (hold_chk) check("hold_stable", 64'(cur), 64'(held));
            if (done) begin
                seen_done = 1'b1;
                start = hold;
                break;
            end
            if (cap.size() == stop_at) break;
            ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            start = (poke && (cyc % 50 == 7)) ? 1'b1 : hold;
            hold_chk = valid && !ready;
            held = cur;
            if (valid && ready) cap.push_back(cur);
            @(negedge clk);
        end
    endtask

    task automatic compare_seq(input string name, input int n_exp);
        check({name, "_count"}, 64'(cap.size()), 64'(n_exp));
        for (int t = 0; t < cap.size() && t < n_exp; t++)
            check(name, 64'(cap[t]), 64'(model[t]));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        ready = 1'b0;
        #12;
        check("reset_state", 64'(sample()), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        build_model();

        // Hand-derived tuples: index into the accepted sequence and fields.
        vecs[0] = '{0,   1'b1, 1'b1, 1'b0, 16'd0,  16'd0,  16'd0};
        vecs[1] = '{9,   1'b0, 1'b0, 1'b0, 16'd1,  16'd9,  16'd0};
        vecs[2] = '{17,  1'b0, 1'b0, 1'b1, 16'd11, 16'd17, 16'd0};
        vecs[3] = '{18,  1'b1, 1'b1, 1'b0, 16'd0,  16'd0,  16'd2};
        vecs[4] = '{98,  1'b0, 1'b0, 1'b0, 16'd10, 16'd8,  16'd10};
        vecs[5] = '{288, 1'b1, 1'b1, 1'b0, 16'd0,  16'd18, 16'd1};
        vecs[6] = '{575, 1'b1, 1'b0, 1'b1, 16'd0,  16'd35, 16'd31};

        // Full sweep with ready held high.
        sweep(1'b0, 1'b0, 1'b0, -1, got_done);
        check("run1_done_seen", 64'(got_done), 64'd1);
        check("run1_done_valid", 64'(valid), 64'd0);
        compare_seq("run1", TOTAL);
        for (int v = 0; v < 7; v++) begin
            if (cap.size() > vecs[v].idx)
                check($sformatf("vec%0d", vecs[v].idx),
                      64'({cap[vecs[v].idx].pad, cap[vecs[v].idx].first, cap[vecs[v].idx].last,
                           cap[vecs[v].idx].s, cap[vecs[v].idx].w, cap[vecs[v].idx].o}),
                      64'({vecs[v].pad, vecs[v].first, vecs[v].last,
                           vecs[v].s, vecs[v].w, vecs[v].o}));
            else
                check($sformatf("vec%0d_missing", vecs[v].idx), 64'(cap.size()), 64'(TOTAL));
        end
        @(negedge clk);
        check("run1_idle", 64'({valid, busy, done}), 64'd0);

        // Random back-pressure plus stray start pulses during the sweep.
        sweep(1'b1, 1'b1, 1'b0, -1, got_done);
        check("run2_done_seen", 64'(got_done), 64'd1);
        compare_seq("run2", TOTAL);
        @(negedge clk);
        check("run2_idle", 64'({valid, busy, done}), 64'd0);

        // Asynchronous reset in the middle of a sweep.
        sweep(1'b0, 1'b0, 1'b0, 100, got_done);
        compare_seq("run3_pre_rst", 100);
        check("run3_mid_valid", 64'(valid), 64'd1);
        #2 rst = 1'b1;
        #1 check("rst_async", 64'(sample()), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_no_resume", 64'({valid, busy, done}), 64'd0);

        // Restart from tuple 0 with start held high through the end of sweep.
        sweep(1'b0, 1'b0, 1'b1, -1, got_done);
        check("run4_done_seen", 64'(got_done), 64'd1);
        compare_seq("run4", TOTAL);
        @(negedge clk);
        check("run4_idle_gap", 64'({valid, busy, done}), 64'd0);
        @(negedge clk);
        check("run4_restart", 64'({valid, busy, first, pad, o_addr}),
              64'({1'b1, 1'b1, 1'b1, 1'b1, 16'd0}));
        start = 1'b0;
        rst   = 1'b1;
        #20;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
